// File: rtl/cyclic_pkg.sv
// Shared types and constants for the cyclic burst controller.
package cyclic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD    = 2'd1,
    ST_WR    = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam int unsigned BEAT_WORDS = 4;
  localparam int unsigned LEN_WIDTH  = 2;

endpackage

// File: rtl/cyclic_rd_fifo.sv
// Two-entry read-return FIFO holding one bank beat plus its word-count tag.
module cyclic_rd_fifo
  import cyclic_pkg::*;
#(
  parameter int unsigned WIDTH = 128
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_data,
  input  logic [LEN_WIDTH-1:0] push_len,
  input  logic                 pop,
  output logic                 valid,
  output logic [1:0]           count,
  output logic [WIDTH-1:0]     head_data,
  output logic [LEN_WIDTH-1:0] head_len
);

  logic [WIDTH-1:0]     data_mem [2];
  logic [LEN_WIDTH-1:0] len_mem  [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           cnt_q;

  // Pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= push_data;
      len_mem[wr_ptr]  <= push_len;
    end
  end

  assign valid     = (cnt_q != 2'd0);
  assign count     = cnt_q;
  assign head_data = data_mem[rd_ptr];
  assign head_len  = len_mem[rd_ptr];

endmodule

// File: rtl/cyclic_burst_ctrl.sv
// Burst controller that splits read/write bursts into up-to-4-word accesses
// on a cyclic (address-wrapping) bank, with a 2-deep read return buffer.
module cyclic_burst_ctrl
  import cyclic_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 9
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_wr,
  input  logic [ADDR_WIDTH-1:0]            cmd_adr,
  input  logic [CNT_WIDTH-1:0]             cmd_cnt,
  input  logic [BEAT_WORDS*DATA_WIDTH-1:0] wdata,
  input  logic                             wdata_valid,
  output logic                             wdata_ready,
  output logic [BEAT_WORDS*DATA_WIDTH-1:0] rdata,
  output logic [LEN_WIDTH-1:0]             rdata_len,
  output logic                             rdata_valid,
  input  logic                             rdata_ready,
  output logic                             mem_re,
  output logic                             mem_we,
  output logic [LEN_WIDTH-1:0]             mem_len,
  output logic [ADDR_WIDTH-1:0]            mem_adr,
  output logic [BEAT_WORDS*DATA_WIDTH-1:0] mem_din,
  input  logic [BEAT_WORDS*DATA_WIDTH-1:0] mem_dout,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned BEAT_BITS = BEAT_WORDS * DATA_WIDTH;

  state_t                state;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [CNT_WIDTH-1:0]  rem_q;
  logic                  inflight_q;
  logic [LEN_WIDTH-1:0]  inflight_len_q;
  logic                  done_q;
  logic                  ready_q;

  logic [CNT_WIDTH-1:0]  beat_words;
  logic [LEN_WIDTH-1:0]  beat_len;
  logic                  active;
  logic                  issue;
  logic                  last_issue;
  logic [2:0]            rd_level;
  logic                  rd_room;

  logic                  fifo_valid;
  logic                  fifo_pop;
  logic [1:0]            fifo_count;
  logic [BEAT_BITS-1:0]  fifo_data;
  logic [LEN_WIDTH-1:0]  fifo_len;

  // Access sizing, read flow control and bank strobes.
  always_comb begin
    beat_words = (rem_q >= CNT_WIDTH'(BEAT_WORDS)) ? CNT_WIDTH'(BEAT_WORDS) : rem_q;
    beat_len   = LEN_WIDTH'(beat_words - CNT_WIDTH'(1));
    active     = (state == ST_RD) || (state == ST_WR);
    fifo_pop   = fifo_valid & rdata_ready;
    rd_level   = 3'(fifo_count) + 3'(inflight_q) - 3'(fifo_pop);
    rd_room    = (rd_level < 3'd2);
    mem_re     = (state == ST_RD) && rd_room;
    mem_we     = (state == ST_WR) && wdata_valid;
    issue      = mem_re | mem_we;
    last_issue = issue && (rem_q <= CNT_WIDTH'(BEAT_WORDS));
    mem_len    = active ? beat_len : '0;
    mem_adr    = adr_q;
    mem_din    = (state == ST_WR) ? wdata : '0;
  end

  assign wdata_ready = (state == ST_WR);
  assign rdata_valid = fifo_valid;
  assign rdata       = fifo_valid ? fifo_data : '0;
  assign rdata_len   = fifo_valid ? fifo_len : '0;
  assign busy        = (state != ST_IDLE);
  assign done        = done_q;
  assign cmd_ready   = ready_q;

  // Burst FSM with registered ready/done.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= ST_IDLE;
      adr_q          <= '0;
      rem_q          <= '0;
      inflight_q     <= 1'b0;
      inflight_len_q <= '0;
      done_q         <= 1'b0;
      ready_q        <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      inflight_q     <= mem_re;
      inflight_len_q <= beat_len;
      if (issue) begin
        adr_q <= adr_q + ADDR_WIDTH'(beat_words);
        rem_q <= rem_q - beat_words;
      end
      case (state)
        ST_IDLE: begin
          ready_q <= 1'b1;
          if (cmd_valid && ready_q) begin
            adr_q <= cmd_adr;
            rem_q <= cmd_cnt;
            if (cmd_cnt == '0) begin
              done_q <= 1'b1;
            end else begin
              state   <= cmd_wr ? ST_WR : ST_RD;
              ready_q <= 1'b0;
            end
          end
        end
        ST_RD: begin
          if (last_issue) state <= ST_FLUSH;
        end
        ST_WR: begin
          if (last_issue) begin
            state   <= ST_IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          // Last beat leaves when the FIFO drains with nothing in flight.
          if (fifo_pop && (fifo_count == 2'd1) && !inflight_q) begin
            state   <= ST_IDLE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  cyclic_rd_fifo #(
    .WIDTH (BEAT_BITS)
  ) u_rd_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight_q),
    .push_data (mem_dout),
    .push_len  (inflight_len_q),
    .pop       (fifo_pop),
    .valid     (fifo_valid),
    .count     (fifo_count),
    .head_data (fifo_data),
    .head_len  (fifo_len)
  );

endmodule
